// File: rtl/mipsfpga_ahb_arbiter_n.sv
// N-master AHB arbiter: fixed-priority or round-robin, burst-aware
// re-arbitration, lock hold, and HREADY-qualified master handoff.
module mipsfpga_ahb_arbiter_n #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic [1:0]             HRESP,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);
    localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    htrans_e       trans;
    hburst_e       burst;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [3:0]    hmaster_q, hmaster_d;
    logic          hmastlock_q, hmastlock_d;
    logic [3:0]    beats_q, beats_d;
    logic          incr_q, incr_d;
    logic [IW-1:0] winner;
    logic [IW-1:0] scan_idx;
    logic          found;
    logic          open_pt;
    logic          lock_hold;

    assign trans = htrans_e'(HTRANS);
    assign burst = hburst_e'(HBURST);

    always_comb begin
        winner   = DEF_IDX;
        found    = 1'b0;
        scan_idx = '0;
        if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!found && HBUSREQ[i]) begin
                    winner = IW'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            // rr_q itself is visited last (k == NUM_MASTERS wraps onto it)
            for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                scan_idx = IW'((32'(rr_q) + k) % NUM_MASTERS);
                if (!found && HBUSREQ[scan_idx]) begin
                    winner = scan_idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        open_pt = (trans == TRANS_IDLE)
               || (trans == TRANS_NONSEQ && burst == BURST_SINGLE)
               || (trans == TRANS_SEQ && beats_q == 4'd1)
               || (incr_q && !HBUSREQ[grant_q])
               || (HRESP != 2'b00);
        lock_hold = HLOCK[grant_q] && HBUSREQ[grant_q];
        if (!HRESETn) begin
            grant_d = DEF_IDX;
        end else if (open_pt && !lock_hold) begin
            grant_d = winner;
        end else begin
            grant_d = grant_q;
        end
        HGRANT          = '0;
        HGRANT[grant_d] = 1'b1;
    end

    always_comb begin
        beats_d     = beats_q;
        incr_d      = incr_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        rr_d        = rr_q;
        // An error/retry/split response aborts the burst even while HREADY is low
        if (HRESP != 2'b00) begin
            beats_d = '0;
            incr_d  = 1'b0;
        end else if (HREADY) begin
            case (trans)
                TRANS_NONSEQ: begin
                    case (burst)
                        BURST_SINGLE, BURST_INCR:   beats_d = 4'd0;
                        BURST_WRAP4, BURST_INCR4:   beats_d = 4'd3;
                        BURST_WRAP8, BURST_INCR8:   beats_d = 4'd7;
                        BURST_WRAP16, BURST_INCR16: beats_d = 4'd15;
                    endcase
                    incr_d = (burst == BURST_INCR);
                end
                TRANS_SEQ: begin
                    if (beats_q != 4'd0) beats_d = beats_q - 4'd1;
                end
                TRANS_IDLE: begin
                    beats_d = '0;
                    incr_d  = 1'b0;
                end
                default: ;
            endcase
        end
        if (HREADY) begin
            hmaster_d   = 4'(grant_d);
            hmastlock_d = HLOCK[grant_d];
            rr_d        = grant_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_q     <= DEF_IDX;
            rr_q        <= DEF_IDX;
            hmaster_q   <= 4'(DEF_IDX);
            hmastlock_q <= 1'b0;
            beats_q     <= '0;
            incr_q      <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            beats_q     <= beats_d;
            incr_q      <= incr_d;
        end
    end

    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_mipsfpga_ahb_arbiter_n.sv
// Directed bench: fixed-priority instance for handoff/lock/error scenarios,
// round-robin instance for rotation order.
module tb_mipsfpga_ahb_arbiter_n;

    localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       HREADY = 1'b1;
    logic [1:0] HTRANS = '0;
    logic [2:0] HBURST = '0;
    logic [1:0] HRESP = '0;
    logic [3:0] HBUSREQ = '0;
    logic [3:0] HLOCK = '0;
    logic [3:0] grant0, grant1;
    logic [3:0] hm0, hm1;
    logic       ml0, ml1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 HCLK = ~HCLK;

    mipsfpga_ahb_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(0), .DEFAULT_MASTER(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS),
        .HBURST(HBURST), .HRESP(HRESP), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HGRANT(grant0), .HMASTER(hm0), .HMASTLOCK(ml0)
    );

    mipsfpga_ahb_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(1), .DEFAULT_MASTER(0)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS),
        .HBURST(HBURST), .HRESP(HRESP), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HGRANT(grant1), .HMASTER(hm1), .HMASTLOCK(ml1)
    );

    task automatic drive(input logic rst_n, input logic rdy, input logic [1:0] tr,
                         input logic [2:0] bu, input logic [1:0] rsp,
                         input logic [3:0] req, input logic [3:0] lck);
        @(negedge HCLK);
        HRESETn = rst_n;
        HREADY  = rdy;
        HTRANS  = tr;
        HBURST  = bu;
        HRESP   = rsp;
        HBUSREQ = req;
        HLOCK   = lck;
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    int rr_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        // Reset
        drive(1'b0, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0000, 4'b0000);
        chk("rst_grant0", 16'(grant0), 16'h0001);
        chk("rst_grant1", 16'(grant1), 16'h0001);
        drive(1'b0, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0000, 4'b0000);
        chk("rst_hmaster", 16'(hm0), 16'd0);
        chk("rst_hmastlock", 16'(ml0), 16'd0);

        // 1: idle bus, master 2 requests
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0100, 4'b0000);
        chk("t1_grant", 16'(grant0), 16'h0004);
        chk("t1_hmaster_hold", 16'(hm0), 16'd0);

        // 2: master 0 INCR4, master 1 requests from beat 2
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0001, 4'b0000);
        chk("t1_hmaster", 16'(hm0), 16'd2);
        chk("t2_grant_m0", 16'(grant0), 16'h0001);
        drive(1'b1, 1'b1, T_NONSEQ, B_INCR4, 2'd0, 4'b0001, 4'b0000);
        chk("t2_hmaster_m0", 16'(hm0), 16'd0);
        chk("t2_beat1", 16'(grant0), 16'h0001);
        drive(1'b1, 1'b1, T_SEQ, B_INCR4, 2'd0, 4'b0011, 4'b0000);
        chk("t2_beat2", 16'(grant0), 16'h0001);
        drive(1'b1, 1'b1, T_SEQ, B_INCR4, 2'd0, 4'b0011, 4'b0000);
        chk("t2_beat3", 16'(grant0), 16'h0001);
        drive(1'b1, 1'b0, T_SEQ, B_INCR4, 2'd0, 4'b0010, 4'b0000);
        chk("t2_beat4_grant", 16'(grant0), 16'h0002);
        chk("t2_beat4_hmaster", 16'(hm0), 16'd0);
        drive(1'b1, 1'b1, T_SEQ, B_INCR4, 2'd0, 4'b0010, 4'b0000);
        chk("t2_wait_grant", 16'(grant0), 16'h0002);
        chk("t2_wait_hmaster", 16'(hm0), 16'd0);
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0010, 4'b0000);
        chk("t2_hmaster_m1", 16'(hm0), 16'd1);

        // 3: master 0 INCR, master 3 waiting 20 cycles
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0001, 4'b0000);
        chk("t3_grant_m0", 16'(grant0), 16'h0001);
        drive(1'b1, 1'b1, T_NONSEQ, B_INCR, 2'd0, 4'b1001, 4'b0000);
        chk("t3_hmaster_m0", 16'(hm0), 16'd0);
        chk("t3_incr_first", 16'(grant0), 16'h0001);
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 1'b1, T_SEQ, B_INCR, 2'd0, 4'b1001, 4'b0000);
            chk("t3_incr_hold", 16'(grant0), 16'h0001);
        end
        drive(1'b1, 1'b1, T_SEQ, B_INCR, 2'd0, 4'b1000, 4'b0000);
        chk("t3_release_grant", 16'(grant0), 16'h0008);

        // 4: locked master 1 vs master 0
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0010, 4'b0010);
        chk("t3_hmaster_m3", 16'(hm0), 16'd3);
        chk("t4_grant_m1", 16'(grant0), 16'h0002);
        drive(1'b1, 1'b1, T_NONSEQ, B_SINGLE, 2'd0, 4'b0011, 4'b0010);
        chk("t4_hmaster_m1", 16'(hm0), 16'd1);
        chk("t4_hmastlock_set", 16'(ml0), 16'd1);
        chk("t4_lock_single", 16'(grant0), 16'h0002);
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0011, 4'b0010);
        chk("t4_lock_idle", 16'(grant0), 16'h0002);
        chk("t4_hmastlock_held", 16'(ml0), 16'd1);
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0001, 4'b0000);
        chk("t4_unlock_grant", 16'(grant0), 16'h0001);
        chk("t4_hmastlock_still", 16'(ml0), 16'd1);

        // 6: master 2 INCR8 (locked beats 1-2), ERROR on beat 3, then reset
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0100, 4'b0100);
        chk("t4_hmastlock_clear", 16'(ml0), 16'd0);
        chk("t4_hmaster_m0", 16'(hm0), 16'd0);
        chk("t6_grant_m2", 16'(grant0), 16'h0004);
        drive(1'b1, 1'b1, T_NONSEQ, B_INCR8, 2'd0, 4'b0101, 4'b0100);
        chk("t6_beat1", 16'(grant0), 16'h0004);
        chk("t6_hmaster_m2", 16'(hm0), 16'd2);
        chk("t6_hmastlock_m2", 16'(ml0), 16'd1);
        drive(1'b1, 1'b1, T_SEQ, B_INCR8, 2'd0, 4'b0101, 4'b0100);
        chk("t6_beat2", 16'(grant0), 16'h0004);
        drive(1'b1, 1'b0, T_SEQ, B_INCR8, 2'd1, 4'b0101, 4'b0000);
        chk("t6_error_grant", 16'(grant0), 16'h0001);
        drive(1'b0, 1'b0, T_IDLE, B_SINGLE, 2'd0, 4'b0100, 4'b0000);
        chk("t6_beats_cleared", 16'(dut0.beats_q), 16'd0);
        chk("t6_rst_grant", 16'(grant0), 16'h0001);
        chk("t6_pre_rst_hmaster", 16'(hm0), 16'd2);
        chk("t6_pre_rst_hmastlock", 16'(ml0), 16'd1);
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0000, 4'b0000);
        chk("t6_rst_hmaster", 16'(hm0), 16'd0);
        chk("t6_rst_hmastlock", 16'(ml0), 16'd0);
        chk("t6_default_grant", 16'(grant0), 16'h0001);
        chk("t5_start_hmaster", 16'(hm1), 16'd0);

        // 5: round-robin with all masters requesting SINGLE transfers
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, T_NONSEQ, B_SINGLE, 2'd0, 4'b1111, 4'b0000);
            chk("t5_rr_grant", 16'(grant1), 16'(16'd1 << rr_seq[i]));
            chk("t5_fixed_grant", 16'(grant0), 16'h0001);
            if (i > 0) chk("t5_rr_hmaster", 16'(hm1), 16'(rr_seq[i-1]));
        end
        drive(1'b1, 1'b1, T_IDLE, B_SINGLE, 2'd0, 4'b0000, 4'b0000);
        chk("t5_rr_hmaster_last", 16'(hm1), 16'(rr_seq[4]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
